traceback_aligner: RTL and testbench
====================================

// Module: traceback_aligner
//
// PURPOSE
// Streaming NW traceback back-end: takes one direction symbol plus SeqA/SeqB characters per beat,
// emits the aligned character pair (dash on gaps) on a valid/ready stream, and accumulates the
// alignment score with linear or affine gap costs. It sits between traceback address generation
// and the result buffer/UART. Successor to the single-score processing stage: adds handshakes,
// saturating width-parametrised scoring, affine gaps, length counting and error reporting.
//
// PARAMETERS
// CH_W      3      width of a sequence character / symbol code
// SCORE_W   12     signed score width; accumulator saturates
// MAX_LEN   256    max aligned columns per run (2*N for N=128)
// LEN_W     9      width of align_len, must hold MAX_LEN
// MATCH     1      score added on diagonal with equal characters
// MISMATCH  -1     score added on diagonal with different characters
// GAP_OPEN  -2     gap cost (linear mode: every gap; affine mode: first gap column)
// GAP_EXT   -1     affine mode: cost of gap column continuing the same direction
// AFFINE    0      0 = linear gaps, 1 = affine gaps
// DASH      3'b111 code emitted for a gap
//
// PORTS
// clk          in   1        clock, rising edge
// rst          in   1        asynchronous, active-low reset (asserted at 0)
// start        in   1        one-cycle pulse: begin a new run (honoured only in IDLE)
// in_valid     in   1        input beat valid
// in_ready     out  1        input beat accepted when in_valid && in_ready
// symbol       in   3        3'b001 diag, 3'b100 left, 3'b010 up; other codes invalid
// seqA_i       in   CH_W     SeqA character for this column
// seqB_j       in   CH_W     SeqB character for this column
// in_last      in   1        marks final traceback beat of the run
// out_valid    out  1        aligned pair valid
// out_ready    in   1        downstream accepts pair when out_valid && out_ready
// datoA        out  CH_W     aligned SeqA character or DASH
// datoB        out  CH_W     aligned SeqB character or DASH
// out_last     out  1        marks final aligned pair
// final_score  out  SCORE_W  signed score, stable from done until next start
// align_len    out  LEN_W    number of emitted columns of the run
// done         out  1        one-cycle pulse at end of run
// error        out  1        sticky: invalid symbol or length overflow; cleared by start
//
// BEHAVIOUR
// - Reset: FSM=IDLE; in_ready, out_valid, out_last, done, error=0; datoA, datoB=0;
//   final_score, align_len=0; internal score=0, prev_dir=NONE. Reset mid-run discards run.
// - FSM IDLE: in_ready=0; start -> RUN, clears score, align_len, error, prev_dir.
// - FSM RUN: in_ready = !out_valid || out_ready (1-deep output register, full throughput).
//   start ignored. On accept with valid symbol: register pair (latency 1), out_valid=1,
//   align_len+1, score updated same edge.
//     diag: datoA=seqA_i, datoB=seqB_j; add MATCH if seqA_i==seqB_j else MISMATCH.
//     left: datoA=DASH, datoB=seqB_j.   up: datoA=seqA_i, datoB=DASH.
//     gap cost: AFFINE=0 -> GAP_OPEN; AFFINE=1 -> GAP_EXT if prev_dir equals this gap
//     direction, else GAP_OPEN. prev_dir <= this direction (diag resets gap run).
//   Invalid symbol: beat consumed, no output, score/len/prev_dir unchanged, error=1.
//   in_last on accepted beat: out_last=1 with that pair (if beat invalid, out_last goes
//   out with DASH/DASH pair, no score); FSM -> DRAIN.
//   Accept making align_len==MAX_LEN without in_last: error=1, that pair forced out_last,
//   FSM -> DRAIN.
// - FSM DRAIN: in_ready=0; when out_valid && out_ready: out_valid=0,
//   final_score<=score, FSM -> DONE.
// - FSM DONE: done=1 for exactly one cycle, -> IDLE. final_score/align_len/error hold.
// - out_valid with out_ready=0: datoA/datoB/out_last held stable until handshake.
// - Arithmetic: score sign-extended; each add saturates at -2^(SCORE_W-1) / 2^(SCORE_W-1)-1.
// - start in same cycle as done: ignored (FSM is not in IDLE).
//
// TESTING
// 1 Linear, out_ready=1: diag(A,A),diag(A,C),left(-,G),up(T,-) last -> pairs AA,AC,-G,T-;
//   final_score=1-1-2-2=-4, align_len=4, done 1 cycle after last handshake.
// 2 AFFINE=1: left,left,left,diag(match) last -> score -2-1-1+1=-3; up,left alternating -> -2 each.
// 3 Backpressure: out_ready low 5 cycles mid-run -> in_ready=0, pair held, no beat lost/duplicated.
// 4 Invalid symbol 3'b011 mid-run -> error=1, no output, score unchanged; next start clears error.
// 5 SCORE_W=4, 10 gaps of -2 -> final_score saturates at -8; MAX_LEN=4 no in_last -> 4 pairs,
//   4th has out_last, error=1.
// 6 rst low during RUN with out_valid=1 -> all outputs 0 async; start re-runs test 1 cleanly.

Source files
------------

// File: rtl/traceback_aligner.sv
// Streaming NW traceback back-end: turns direction symbols into aligned
// character pairs on a valid/ready stream and accumulates a saturating score.
module traceback_aligner #(
  parameter int CH_W     = 3,
  parameter int SCORE_W  = 12,
  parameter int MAX_LEN  = 256,
  parameter int LEN_W    = 9,
  parameter int MATCH    = 1,
  parameter int MISMATCH = -1,
  parameter int GAP_OPEN = -2,
  parameter int GAP_EXT  = -1,
  parameter int AFFINE   = 0,
  parameter logic [CH_W-1:0] DASH = {CH_W{1'b1}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2:0]                symbol,
  input  logic [CH_W-1:0]           seqA_i,
  input  logic [CH_W-1:0]           seqB_j,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CH_W-1:0]           datoA,
  output logic [CH_W-1:0]           datoB,
  output logic                      out_last,
  output logic signed [SCORE_W-1:0] final_score,
  output logic [LEN_W-1:0]          align_len,
  output logic                      done,
  output logic                      error
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    D_NONE, D_DIAG, D_LEFT, D_UP
  } dir_t;

  localparam int SMAX = 2**(SCORE_W-1) - 1;
  localparam int SMIN = -(2**(SCORE_W-1));

  state_t                      r_state;
  dir_t                        r_prev;
  logic signed [SCORE_W-1:0]   r_score;

  logic                        w_acc;
  logic                        w_ok;
  dir_t                        w_dir;
  logic [CH_W-1:0]             w_a;
  logic [CH_W-1:0]             w_b;
  logic signed [31:0]          w_delta;
  logic signed [31:0]          w_sum;
  logic signed [SCORE_W-1:0]   w_nscore;
  logic [LEN_W-1:0]            w_len_nxt;
  logic                        w_ovf;

  assign in_ready = (r_state == S_RUN) && (!out_valid || out_ready);
  assign w_acc    = in_valid && in_ready;

  always_comb begin
    w_ok    = 1'b1;
    w_dir   = D_NONE;
    w_a     = DASH;
    w_b     = DASH;
    w_delta = '0;
    unique case (1'b1)
      (symbol == 3'b001): begin
        w_dir   = D_DIAG;
        w_a     = seqA_i;
        w_b     = seqB_j;
        w_delta = (seqA_i == seqB_j) ? MATCH : MISMATCH;
      end
      (symbol == 3'b100): begin
        w_dir   = D_LEFT;
        w_b     = seqB_j;
        w_delta = (AFFINE != 0 && r_prev == D_LEFT)
                  ? GAP_EXT : GAP_OPEN;
      end
      (symbol == 3'b010): begin
        w_dir   = D_UP;
        w_a     = seqA_i;
        w_delta = (AFFINE != 0 && r_prev == D_UP)
                  ? GAP_EXT : GAP_OPEN;
      end
      default: w_ok = 1'b0;
    endcase
  end

  // Saturate in 32-bit space, then narrow back to the score width
  always_comb begin
    w_sum = 32'(r_score) + w_delta;
    if (w_sum > SMAX)
      w_nscore = SCORE_W'(SMAX);
    else if (w_sum < SMIN)
      w_nscore = SCORE_W'(SMIN);
    else
      w_nscore = SCORE_W'(w_sum);
  end

  assign w_len_nxt = align_len + 1'b1;
  assign w_ovf     = (w_len_nxt == LEN_W'(MAX_LEN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_prev      <= D_NONE;
      r_score     <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      datoA       <= '0;
      datoB       <= '0;
      final_score <= '0;
      align_len   <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_score   <= '0;
            r_prev    <= D_NONE;
            align_len <= '0;
            error     <= 1'b0;
          end
        end
        S_RUN: begin
          if (out_valid && out_ready)
            out_valid <= 1'b0;
          if (w_acc) begin
            if (w_ok) begin
              datoA     <= w_a;
              datoB     <= w_b;
              out_valid <= 1'b1;
              out_last  <= in_last || w_ovf;
              r_score   <= w_nscore;
              r_prev    <= w_dir;
              align_len <= w_len_nxt;
              if (w_ovf && !in_last)
                error <= 1'b1;
              if (in_last || w_ovf)
                r_state <= S_DRAIN;
            end else begin
              error <= 1'b1;
              if (in_last) begin
                datoA     <= DASH;
                datoB     <= DASH;
                out_valid <= 1'b1;
                out_last  <= 1'b1;
                r_state   <= S_DRAIN;
              end
            end
          end
        end
        S_DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            final_score <= r_score;
            done        <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_traceback_aligner.sv
// Bench for traceback_aligner: directed and random runs on four
// parameterisations, checked against a queue-based reference model.
module tb_traceback_aligner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start;
  logic       in_valid;
  logic [2:0] symbol;
  logic [2:0] sa;
  logic [2:0] sb;
  logic       in_last;
  logic       out_ready;

  wire              ir_w [4];
  wire              ov_w [4];
  wire [2:0]        a_w  [4];
  wire [2:0]        b_w  [4];
  wire              ol_w [4];
  wire signed [11:0] fs_w [4];
  wire [8:0]        len_w [4];
  wire              dn_w [4];
  wire              er_w [4];

  wire signed [3:0] fs2;
  wire [4:0]        len2;
  wire [2:0]        len3;

  assign fs_w[2]  = {{8{fs2[3]}}, fs2};
  assign len_w[2] = {4'b0, len2};
  assign len_w[3] = {6'b0, len3};

  always #5 clk = ~clk;

  traceback_aligner u0 (
    .clk(clk), .rst(rst), .start(start[0]),
    .in_valid(in_valid), .in_ready(ir_w[0]),
    .symbol(symbol), .seqA_i(sa), .seqB_j(sb),
    .in_last(in_last), .out_valid(ov_w[0]),
    .out_ready(out_ready), .datoA(a_w[0]),
    .datoB(b_w[0]), .out_last(ol_w[0]),
    .final_score(fs_w[0]), .align_len(len_w[0]),
    .done(dn_w[0]), .error(er_w[0]));

  traceback_aligner #(.AFFINE(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .in_valid(in_valid), .in_ready(ir_w[1]),
    .symbol(symbol), .seqA_i(sa), .seqB_j(sb),
    .in_last(in_last), .out_valid(ov_w[1]),
    .out_ready(out_ready), .datoA(a_w[1]),
    .datoB(b_w[1]), .out_last(ol_w[1]),
    .final_score(fs_w[1]), .align_len(len_w[1]),
    .done(dn_w[1]), .error(er_w[1]));

  traceback_aligner #(
    .SCORE_W(4), .MAX_LEN(16), .LEN_W(5)
  ) u2 (
    .clk(clk), .rst(rst), .start(start[2]),
    .in_valid(in_valid), .in_ready(ir_w[2]),
    .symbol(symbol), .seqA_i(sa), .seqB_j(sb),
    .in_last(in_last), .out_valid(ov_w[2]),
    .out_ready(out_ready), .datoA(a_w[2]),
    .datoB(b_w[2]), .out_last(ol_w[2]),
    .final_score(fs2), .align_len(len2),
    .done(dn_w[2]), .error(er_w[2]));

  traceback_aligner #(.MAX_LEN(4), .LEN_W(3)) u3 (
    .clk(clk), .rst(rst), .start(start[3]),
    .in_valid(in_valid), .in_ready(ir_w[3]),
    .symbol(symbol), .seqA_i(sa), .seqB_j(sb),
    .in_last(in_last), .out_valid(ov_w[3]),
    .out_ready(out_ready), .datoA(a_w[3]),
    .datoB(b_w[3]), .out_last(ol_w[3]),
    .final_score(fs_w[3]), .align_len(len_w[3]),
    .done(dn_w[3]), .error(er_w[3]));

  int p_sw [4] = '{12, 12, 4, 12};
  int p_ml [4] = '{256, 256, 16, 4};
  int p_af [4] = '{0, 1, 0, 0};

  int checks = 0;
  int errors = 0;

  logic [2:0] bsym [$];
  logic [2:0] ba   [$];
  logic [2:0] bb   [$];
  bit         blast[$];

  logic [6:0] eq [$];
  int         escore;
  int         elen;
  int         eerr;
  int         ncons;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bsym.delete(); ba.delete(); bb.delete(); blast.delete();
  endtask

  task automatic add(input logic [2:0] s, input logic [2:0] a,
                     input logic [2:0] b, input bit l);
    bsym.push_back(s); ba.push_back(a);
    bb.push_back(b); blast.push_back(l);
  endtask

  // Column-by-column scoring straight from the alignment rules
  task automatic model(input int s);
    int prev, d, hi, lo;
    logic [2:0] pa, pb;
    bit ol;
    hi = (1 << (p_sw[s] - 1)) - 1;
    lo = -(1 << (p_sw[s] - 1));
    eq.delete();
    escore = 0; elen = 0; eerr = 0; ncons = 0; prev = 0;
    for (int i = 0; i < bsym.size(); i++) begin
      ncons++;
      if (bsym[i] == 3'b001) begin
        d = (ba[i] == bb[i]) ? 1 : -1;
        pa = ba[i]; pb = bb[i]; prev = 1;
      end else if (bsym[i] == 3'b100) begin
        d = (p_af[s] != 0 && prev == 2) ? -1 : -2;
        pa = 3'b111; pb = bb[i]; prev = 2;
      end else if (bsym[i] == 3'b010) begin
        d = (p_af[s] != 0 && prev == 3) ? -1 : -2;
        pa = ba[i]; pb = 3'b111; prev = 3;
      end else begin
        eerr = 1;
        if (blast[i]) begin
          eq.push_back({3'b111, 3'b111, 1'b1});
          break;
        end
        continue;
      end
      escore = escore + d;
      if (escore > hi) escore = hi;
      if (escore < lo) escore = lo;
      elen++;
      ol = blast[i] || (elen == p_ml[s]);
      if (elen == p_ml[s] && !blast[i]) eerr = 1;
      eq.push_back({pa, pb, ol});
      if (ol) break;
    end
  endtask

  task automatic run(input int s, input bit bp);
    int bi, oi, cyc;
    bit hold;
    logic [6:0] held;
    model(s);
    @(negedge clk);
    chk("idle_in_ready", ir_w[s], 0);
    start[s] = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    bi = 0; oi = 0; cyc = 0; hold = 0; held = '0;
    while (oi < eq.size() && cyc < 3000) begin
      cyc++;
      if (bi < ncons) begin
        in_valid = ($urandom_range(0, 3) != 0);
        symbol = bsym[bi]; sa = ba[bi];
        sb = bb[bi]; in_last = blast[bi];
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      if (hold)
        chk("hold", {a_w[s], b_w[s], ol_w[s]}, held);
      if (ov_w[s] && !out_ready)
        chk("bp_in_ready", ir_w[s], 0);
      hold = ov_w[s] && !out_ready;
      held = {a_w[s], b_w[s], ol_w[s]};
      if (in_valid && ir_w[s]) bi++;
      if (ov_w[s] && out_ready) begin
        chk("pair", {a_w[s], b_w[s], ol_w[s]}, eq[oi]);
        oi++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    if (oi < eq.size())
      chk("timeout_pairs", oi, eq.size());
    #1;
    chk("done_pulse", dn_w[s], 1);
    chk("final_score", fs_w[s], escore);
    chk("align_len", len_w[s], elen);
    chk("error", er_w[s], eerr);
    chk("beats_taken", bi, ncons);
    @(negedge clk);
    #1;
    chk("done_low", dn_w[s], 0);
  endtask

  task automatic rand_run(input int s);
    int n, r;
    logic [2:0] sy;
    clr();
    n = $urandom_range(1, 20);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 4 || r == 9) sy = 3'b001;
      else if (r < 6) sy = 3'b100;
      else if (r < 8) sy = 3'b010;
      else sy = 3'b011;
      add(sy, 3'($urandom_range(0, 3)),
          3'($urandom_range(0, 3)), i == n - 1);
    end
    run(s, 1'b1);
  endtask

  task automatic test1();
    clr();
    add(3'b001, 3'd0, 3'd0, 0);
    add(3'b001, 3'd0, 3'd1, 0);
    add(3'b100, 3'd5, 3'd2, 0);
    add(3'b010, 3'd3, 3'd6, 1);
    run(0, 1'b0);
    chk("t1_score", fs_w[0], -4);
    chk("t1_len", len_w[0], 4);
  endtask

  initial begin
    rst = 1'b0; start = '0; in_valid = 1'b0;
    symbol = '0; sa = '0; sb = '0;
    in_last = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_ov", ov_w[0], 0);
    chk("rst_ir", ir_w[0], 0);
    chk("rst_a", a_w[0], 0);
    chk("rst_fs", fs_w[0], 0);
    chk("rst_len", len_w[0], 0);
    chk("rst_err", er_w[0], 0);
    chk("rst_done", dn_w[0], 0);
    @(negedge clk);
    rst = 1'b1;

    test1();

    clr();
    add(3'b100, 3'd0, 3'd1, 0);
    add(3'b100, 3'd0, 3'd2, 0);
    add(3'b100, 3'd0, 3'd3, 0);
    add(3'b001, 3'd2, 3'd2, 1);
    run(1, 1'b0);
    chk("aff_score", fs_w[1], -3);

    clr();
    add(3'b010, 3'd1, 3'd0, 0);
    add(3'b100, 3'd0, 3'd1, 0);
    add(3'b010, 3'd2, 3'd0, 0);
    add(3'b100, 3'd0, 3'd2, 1);
    run(1, 1'b0);
    chk("aff_alt", fs_w[1], -8);

    clr();
    for (int i = 0; i < 12; i++)
      add(3'b001, 3'(i % 4), 3'((i / 2) % 4), i == 11);
    run(0, 1'b1);

    clr();
    add(3'b001, 3'd0, 3'd0, 0);
    add(3'b011, 3'd1, 3'd1, 0);
    add(3'b100, 3'd0, 3'd1, 1);
    run(0, 1'b0);
    chk("inv_err", er_w[0], 1);
    chk("inv_score", fs_w[0], -1);
    chk("inv_len", len_w[0], 2);
    test1();
    chk("err_cleared", er_w[0], 0);

    clr();
    for (int i = 0; i < 10; i++)
      add(3'b100, 3'd0, 3'd1, i == 9);
    run(2, 1'b0);
    chk("sat_score", fs_w[2], -8);

    clr();
    for (int i = 0; i < 6; i++)
      add(3'b001, 3'd1, 3'd1, 0);
    run(3, 1'b0);
    chk("ovf_len", len_w[3], 4);
    chk("ovf_err", er_w[3], 1);

    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    in_valid = 1'b1; symbol = 3'b001;
    sa = 3'd2; sb = 3'd2; in_last = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_ov", ov_w[0], 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ov", ov_w[0], 0);
    chk("arst_a", a_w[0], 0);
    chk("arst_b", b_w[0], 0);
    chk("arst_ol", ol_w[0], 0);
    chk("arst_ir", ir_w[0], 0);
    chk("arst_fs", fs_w[0], 0);
    chk("arst_len", len_w[0], 0);
    chk("arst_err", er_w[0], 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    test1();

    for (int k = 0; k < 12; k++)
      rand_run(k % 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
